// File: rtl/snn_pkg.sv
// Shared constants and state type for the host->SNN image loader.
package snn_pkg;

  localparam int unsigned NUM_PIXELS    = 784;
  localparam int unsigned PIX_PER_BYTE  = 8;
  localparam int unsigned BYTES_PER_IMG = NUM_PIXELS / PIX_PER_BYTE;

  typedef enum logic [1:0] {
    StLoad,
    StUnpack,
    StFull
  } loader_state_t;

endpackage

// File: rtl/snn_byte_unpacker.sv
// Byte-to-pixel serialiser: 1-deep hold register, LSB-first shift register and bit counter.
module snn_byte_unpacker
  import snn_pkg::*;
#(
  localparam int unsigned CntW = $clog2(PIX_PER_BYTE)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [7:0]      rx_byte_i,
  input  logic            hold_wr_i,
  input  logic            hold_pop_i,
  input  logic            load_i,
  input  logic            load_from_hold_i,
  input  logic            shift_i,
  output logic            hold_vld_o,
  output logic            bit_o,
  output logic [CntW-1:0] bit_idx_o,
  output logic            done_o
);

  logic [7:0]      hold_q, hold_d;
  logic            hold_vld_q, hold_vld_d;
  logic [7:0]      sh_q, sh_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    sh_d       = sh_q;
    cnt_d      = cnt_q;
    // A write in the same cycle as a pop refills the slot that is being consumed
    if (hold_wr_i) begin
      hold_d     = rx_byte_i;
      hold_vld_d = 1'b1;
    end else if (hold_pop_i) begin
      hold_vld_d = 1'b0;
    end
    if (load_i) begin
      sh_d  = load_from_hold_i ? hold_q : rx_byte_i;
      cnt_d = '0;
    end else if (shift_i) begin
      sh_d  = {1'b0, sh_q[7:1]};
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      sh_q       <= '0;
      cnt_q      <= '0;
    end else begin
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      sh_q       <= sh_d;
      cnt_q      <= cnt_d;
    end
  end

  assign hold_vld_o = hold_vld_q;
  assign bit_o      = sh_q[0];
  assign bit_idx_o  = cnt_q;
  assign done_o     = shift_i && (cnt_q == CntW'(PIX_PER_BYTE - 1));

endmodule

// File: rtl/snn_image_loader.sv
// Unpacks received UART bytes into single-bit pixel RAM writes and hands full images to the core.
// Optional idle timeout for partial frames is enabled by defining RX_TIMEOUT_EN.
module snn_image_loader
  import snn_pkg::*;
#(
  parameter int unsigned NumPixels = NUM_PIXELS,
  parameter int unsigned AddrW     = 10
`ifdef RX_TIMEOUT_EN
  ,
  parameter int unsigned TimeoutCyc = 26040
`endif
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             rx_rdy_i,
  input  logic [7:0]       rx_data_i,
  input  logic             img_ack_i,
  output logic             pix_we_o,
  output logic [AddrW-1:0] pix_addr_o,
  output logic             pix_wdata_o,
  output logic             img_rdy_o,
  output logic             frame_err_o
);

  localparam int unsigned BytesPerImg = NumPixels / PIX_PER_BYTE;
  localparam int unsigned IdxW        = (BytesPerImg > 1) ? $clog2(BytesPerImg) : 1;
  localparam int unsigned CntW        = $clog2(PIX_PER_BYTE);

  loader_state_t   state_q, state_d;
  logic [IdxW-1:0] byte_idx_q, byte_idx_d;
  logic [AddrW-1:0] addr_q, cur_addr;
  logic            err_q, err_d, err_set, err_clr;
  logic            load, load_from_hold, hold_wr, hold_pop, shift;
  logic            hold_vld, bit_val, done, last_byte, timeout;
  logic [CntW-1:0] bit_idx;

  snn_byte_unpacker u_unpacker (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .rx_byte_i        (rx_data_i),
    .hold_wr_i        (hold_wr),
    .hold_pop_i       (hold_pop),
    .load_i           (load),
    .load_from_hold_i (load_from_hold),
    .shift_i          (shift),
    .hold_vld_o       (hold_vld),
    .bit_o            (bit_val),
    .bit_idx_o        (bit_idx),
    .done_o           (done)
  );

  assign shift     = (state_q == StUnpack);
  assign last_byte = (byte_idx_q == IdxW'(BytesPerImg - 1));
  assign cur_addr  = AddrW'({byte_idx_q, bit_idx});

`ifdef RX_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TimeoutCyc + 1);
  logic [TW-1:0] idle_q, idle_d;
  logic          idle_run;

  assign idle_run = (state_q == StLoad) && (byte_idx_q != '0) && !rx_rdy_i && !hold_vld;
  assign timeout  = idle_run && (idle_q == TW'(TimeoutCyc - 1));
  assign idle_d   = (idle_run && !timeout) ? idle_q + 1'b1 : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) idle_q <= '0;
    else         idle_q <= idle_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    byte_idx_d     = byte_idx_q;
    load           = 1'b0;
    load_from_hold = 1'b0;
    hold_wr        = 1'b0;
    hold_pop       = 1'b0;
    err_set        = 1'b0;
    err_clr        = 1'b0;
    unique case (state_q)
      StLoad: begin
        if (hold_vld) begin
          load           = 1'b1;
          load_from_hold = 1'b1;
          hold_pop       = 1'b1;
          hold_wr        = rx_rdy_i;
          state_d        = StUnpack;
        end else if (rx_rdy_i) begin
          load    = 1'b1;
          state_d = StUnpack;
        end else if (timeout) begin
          byte_idx_d = '0;
          err_set    = 1'b1;
        end
      end
      StUnpack: begin
        if (done) begin
          if (last_byte) begin
            state_d = StFull;
          end else begin
            byte_idx_d = byte_idx_q + 1'b1;
            if (hold_vld) begin
              load           = 1'b1;
              load_from_hold = 1'b1;
              hold_pop       = 1'b1;
            end else begin
              state_d = StLoad;
            end
          end
        end
        // The hold slot is free again only if it is being consumed this very cycle
        if (rx_rdy_i) begin
          if (hold_vld && !hold_pop) err_set = 1'b1;
          else                       hold_wr = 1'b1;
        end
      end
      StFull: begin
        if (img_ack_i) begin
          state_d    = StLoad;
          byte_idx_d = '0;
          err_clr    = 1'b1;
          if (rx_rdy_i) begin
            if (hold_vld) err_set = 1'b1;
            else          hold_wr = 1'b1;
          end
        end else if (rx_rdy_i) begin
          err_set = 1'b1;
        end
      end
      default: state_d = StLoad;
    endcase
  end

  assign err_d = err_set | (err_q & ~err_clr);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StLoad;
      byte_idx_q <= '0;
      addr_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      addr_q     <= shift ? cur_addr : addr_q;
      err_q      <= err_d;
    end
  end

  assign pix_we_o    = shift;
  assign pix_addr_o  = shift ? cur_addr : addr_q;
  assign pix_wdata_o = shift & bit_val;
  assign img_rdy_o   = (state_q == StFull);
  assign frame_err_o = err_q;

endmodule

// File: tb/tb_snn_image_loader.sv
// Self-checking bench for snn_image_loader: randomized byte streams against a pixel-write model.
module tb_snn_image_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_rdy;
  logic [7:0] rx_data;
  logic       img_ack;
  logic       pix_we;
  logic [9:0] pix_addr;
  logic       pix_wdata;
  logic       img_rdy;
  logic       frame_err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int obs_q[$];
  int exp_q[$];
  int w_last_cyc = -1;
  int rdy_cyc    = -1;
  bit rdy_seen   = 1'b0;

  snn_image_loader dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .rx_rdy_i    (rx_rdy),
    .rx_data_i   (rx_data),
    .img_ack_i   (img_ack),
    .pix_we_o    (pix_we),
    .pix_addr_o  (pix_addr),
    .pix_wdata_o (pix_wdata),
    .img_rdy_o   (img_rdy),
    .frame_err_o (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Every RAM write is logged as addr*2+data
  always @(negedge clk) begin
    if (pix_we === 1'b1) begin
      obs_q.push_back(int'(pix_addr) * 2 + int'(pix_wdata));
      if (pix_addr == 10'd783) w_last_cyc = cyc;
    end
    if (img_rdy === 1'b1 && !rdy_seen) begin
      rdy_seen = 1'b1;
      rdy_cyc  = cyc;
    end
  end

  // Expected image content: byte k, bit b lands at pixel 8k+b
  function automatic void model_byte(input logic [7:0] b, input int k);
    for (int i = 0; i < 8; i++) exp_q.push_back((8 * k + i) * 2 + int'(b[i]));
  endfunction

  task automatic clear_logs();
    obs_q.delete();
    exp_q.delete();
    rdy_seen = 1'b0;
  endtask

  task automatic do_reset();
    rx_rdy  = 1'b0;
    rx_data = 8'h00;
    img_ack = 1'b0;
    rst_n   = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    clear_logs();
  endtask

  // Inputs change 1 time unit after a rising edge; tasks start and end at that phase.
  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_rdy  = 1'b1;
    rx_data = b;
    @(posedge clk);
    #1 rx_rdy = 1'b0;
    for (int i = 0; i < gap; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_ack();
    img_ack = 1'b1;
    @(posedge clk);
    #1 img_ack = 1'b0;
  endtask

  task automatic fill_frame(input int nbytes, input int gap_lo, input int gap_hi);
    logic [7:0] b;
    for (int k = 0; k < nbytes; k++) begin
      b = 8'($urandom);
      model_byte(b, k);
      send_byte(b, (k == nbytes - 1) ? 20 : int'($urandom_range(gap_hi, gap_lo)));
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    do_reset();
    n_tests++; if (pix_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b want 0", pix_we); end
    n_tests++; if (pix_addr !== 10'd0) begin n_fail++; $display("FAIL reset_addr got %0d want 0", pix_addr); end
    n_tests++; if (pix_wdata !== 1'b0) begin n_fail++; $display("FAIL reset_wdata got %b want 0", pix_wdata); end
    n_tests++; if (img_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_rdy got %b want 0", img_rdy); end
    n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", frame_err); end
  endtask

  task automatic test_full_image();
    clear_logs();
    for (int k = 0; k < 98; k++) begin
      model_byte(8'hA5, k);
      send_byte(8'hA5, (k == 97) ? 11 : 11);
    end
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL a5_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL a5_write[%0d] got addr %0d data %0d want addr %0d data %0d", i,
                 obs_q[i] / 2, obs_q[i] % 2, exp_q[i] / 2, exp_q[i] % 2);
      end
    end
    n_tests++; if (img_rdy !== 1'b1) begin n_fail++; $display("FAIL a5_rdy got %b want 1", img_rdy); end
    n_tests++;
    if (rdy_cyc != w_last_cyc + 1) begin
      n_fail++; $display("FAIL a5_rdy_timing got cycle %0d want %0d", rdy_cyc, w_last_cyc + 1);
    end
    n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL a5_err got %b want 0", frame_err); end
    pulse_ack();
    n_tests++; if (img_rdy !== 1'b0) begin n_fail++; $display("FAIL a5_ack_rdy got %b want 0", img_rdy); end
  endtask

  task automatic test_back_to_back();
    clear_logs();
    fill_frame(98, 7, 14);
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL b2b_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL b2b_write[%0d] got addr %0d data %0d want addr %0d data %0d", i,
                 obs_q[i] / 2, obs_q[i] % 2, exp_q[i] / 2, exp_q[i] % 2);
      end
    end
    n_tests++; if (img_rdy !== 1'b1) begin n_fail++; $display("FAIL b2b_rdy got %b want 1", img_rdy); end
    n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL b2b_err got %b want 0", frame_err); end
    pulse_ack();
  endtask

  task automatic test_overrun();
    logic [7:0] b0, b1, b2, b3;
    clear_logs();
    b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom); b3 = 8'($urandom);
    model_byte(b0, 0);
    model_byte(b1, 1);
    model_byte(b2, 2);
    send_byte(b0, 11);
    rx_rdy = 1'b1; rx_data = b1;
    @(posedge clk); #1 rx_data = b2;
    @(posedge clk); #1 rx_data = b3;
    @(posedge clk); #1 rx_rdy = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL ovr_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL ovr_write[%0d] got addr %0d data %0d want addr %0d data %0d", i,
                 obs_q[i] / 2, obs_q[i] % 2, exp_q[i] / 2, exp_q[i] % 2);
      end
    end
    n_tests++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL ovr_err got %b want 1", frame_err); end
    do_reset();
  endtask

  task automatic test_full_drop();
    clear_logs();
    fill_frame(98, 9, 12);
    obs_q.delete();
    send_byte(8'h01, 10);
    n_tests++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL drop_writes got %0d want 0", obs_q.size()); end
    n_tests++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL drop_err got %b want 1", frame_err); end
    n_tests++; if (img_rdy !== 1'b1) begin n_fail++; $display("FAIL drop_rdy got %b want 1", img_rdy); end
    pulse_ack();
    n_tests++; if (img_rdy !== 1'b0) begin n_fail++; $display("FAIL drop_ack_rdy got %b want 0", img_rdy); end
    n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL drop_ack_err got %b want 0", frame_err); end
  endtask

  task automatic test_ack_with_byte();
    clear_logs();
    fill_frame(98, 9, 13);
    clear_logs();
    model_byte(8'hFF, 0);
    img_ack = 1'b1;
    send_byte(8'hFF, 15);
    img_ack = 1'b0;
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL ackb_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL ackb_write[%0d] got addr %0d data %0d want addr %0d data %0d", i,
                 obs_q[i] / 2, obs_q[i] % 2, exp_q[i] / 2, exp_q[i] % 2);
      end
    end
    n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL ackb_err got %b want 0", frame_err); end
    n_tests++; if (img_rdy !== 1'b0) begin n_fail++; $display("FAIL ackb_rdy got %b want 0", img_rdy); end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    fill_frame(40, 9, 12);
    do_reset();
    fill_frame(97, 9, 12);
    n_tests++; if (img_rdy !== 1'b0) begin n_fail++; $display("FAIL rst_early_rdy got %b want 0", img_rdy); end
    begin
      logic [7:0] b;
      b = 8'($urandom);
      model_byte(b, 97);
      send_byte(b, 12);
    end
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL rst_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL rst_write[%0d] got addr %0d data %0d want addr %0d data %0d", i,
                 obs_q[i] / 2, obs_q[i] % 2, exp_q[i] / 2, exp_q[i] % 2);
      end
    end
    n_tests++; if (img_rdy !== 1'b1) begin n_fail++; $display("FAIL rst_rdy got %b want 1", img_rdy); end
    pulse_ack();
  endtask

  task automatic test_timeout();
    logic [7:0] b;
    logic       err_want;
    int         next_idx;
`ifdef RX_TIMEOUT_EN
    err_want = 1'b1;
    next_idx = 0;
`else
    err_want = 1'b0;
    next_idx = 10;
`endif
    do_reset();
    fill_frame(10, 9, 12);
    obs_q.delete();
    exp_q.delete();
    repeat (26040 + 20) @(posedge clk);
    #1;
    n_tests++; if (frame_err !== err_want) begin n_fail++; $display("FAIL tmo_err got %b want %b", frame_err, err_want); end
    b = 8'($urandom);
    model_byte(b, next_idx);
    send_byte(b, 12);
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL tmo_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL tmo_write[%0d] got addr %0d data %0d want addr %0d data %0d", i,
                 obs_q[i] / 2, obs_q[i] % 2, exp_q[i] / 2, exp_q[i] % 2);
      end
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    rx_rdy  = 1'b0;
    rx_data = 8'h00;
    img_ack = 1'b0;
    test_reset();
    test_full_image();
    test_back_to_back();
    test_overrun();
    test_full_drop();
    test_ack_with_byte();
    test_reset_midframe();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
